// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue/response controller for the 9-stage 32x32 signed multiplier
// Metadata pipe tracks the multiplier; results land in a credit-protected output FIFO.
module mul_issue_ctrl #(
  parameter int LAT       = 9,
  parameter int TAG_W     = 5,
  parameter int OUT_DEPTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [31:0]      i_req_rs1,
  input  logic [31:0]      i_req_rs2,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic [31:0]      o_mul_a,
  output logic [31:0]      o_mul_b,
  output logic             o_mul_en,
  input  logic [63:0]      i_mul_p,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [31:0]      o_resp_data,
  output logic [TAG_W-1:0] o_resp_tag,
  output logic             o_busy
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic [CNT_W-1:0]           r_inflight;
  logic [CNT_W-1:0]           r_fifo_count;
  logic [CNT_W:0]             w_credit_used;
  logic                       w_accept;
  logic                       w_wr;
  logic                       w_pop;
  logic [31:0]                w_corr;
  logic [31:0]                w_result;

  logic [LAT-1:0]             r_v;
  logic [LAT-1:0][1:0]        r_op;
  logic [LAT-1:0][TAG_W-1:0]  r_tag;
  logic [LAT-1:0][31:0]       r_corr;

  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [TAG_W+31:0]          r_mem [OUT_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover every op from accept until pop, so the FIFO can never overflow.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_fifo_count};
  assign o_req_ready   = !i_rst && !i_flush && (w_credit_used < (CNT_W+1)'(OUT_DEPTH));
  assign w_accept      = i_req_valid && o_req_ready;

  assign o_mul_a  = w_accept ? i_req_rs1 : 32'd0;
  assign o_mul_b  = w_accept ? i_req_rs2 : 32'd0;
  assign o_mul_en = 1'b1;

  assign w_wr  = r_v[LAT-1];
  assign w_pop = o_resp_valid && i_resp_ready;

  always_comb begin
    w_corr = 32'd0;
    case (i_req_op)
      OP_MULHU:  w_corr = (i_req_rs1[31] ? i_req_rs2 : 32'd0) + (i_req_rs2[31] ? i_req_rs1 : 32'd0);
      OP_MULHSU: w_corr = i_req_rs2[31] ? i_req_rs1 : 32'd0;
      default:   w_corr = 32'd0;
    endcase
  end

  // The multiplier is signed; unsigned operands are fixed up in the high word only.
  always_comb begin
    w_result = i_mul_p[63:32];
    case (r_op[LAT-1])
      OP_MUL:    w_result = i_mul_p[31:0];
      OP_MULH:   w_result = i_mul_p[63:32];
      OP_MULHSU,
      OP_MULHU:  w_result = i_mul_p[63:32] + r_corr[LAT-1];
      default:   w_result = i_mul_p[63:32];
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v          <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else if (i_flush) begin
      r_v          <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_v <= {r_v[LAT-2:0], w_accept};
      case ({w_accept, w_wr})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_wr, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
      if (w_wr) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
    end
  end

  // Payload follows r_v; stale payload in empty stages is never used.
  always_ff @(posedge i_clk) begin
    r_op   <= {r_op[LAT-2:0], i_req_op};
    r_tag  <= {r_tag[LAT-2:0], i_req_tag};
    r_corr <= {r_corr[LAT-2:0], w_corr};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
    end else if (!i_flush && w_wr) begin
      r_mem[r_wr_ptr] <= {r_tag[LAT-1], w_result};
    end
  end

  assign o_resp_valid = (r_fifo_count != '0);
  assign o_resp_data  = r_mem[r_rd_ptr][31:0];
  assign o_resp_tag   = r_mem[r_rd_ptr][TAG_W+31:32];
  assign o_busy       = (r_inflight != '0) || (r_fifo_count != '0);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
    !(w_wr && !w_pop && (r_fifo_count == CNT_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed self-checking bench for mul_issue_ctrl
// Bench supplies a 9-stage signed multiplier model and a scoreboard of expected results.
module tb_mul_issue_ctrl;
  localparam int LAT       = 9;
  localparam int TAG_W     = 5;
  localparam int OUT_DEPTH = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [31:0]      rs1 = 32'd0;
  logic [31:0]      rs2 = 32'd0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_en;
  logic [63:0]      mul_p;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  logic [63:0]      mpipe [LAT];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic             hand_on = 1'b0;
  logic [31:0]      hand_val = 32'd0;
  logic [TAG_W+31:0] expq [$];
  int               pop_cyc [$];

  mul_issue_ctrl #(.LAT(LAT), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_rs1(rs1), .i_req_rs2(rs2), .i_req_tag(req_tag),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_en(mul_en), .i_mul_p(mul_p),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(resp_data), .o_resp_tag(resp_tag), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= 64'd0;
    end else begin
      mpipe[0] <= 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p = mpipe[LAT-1];

  function automatic logic [31:0] gold(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00:   begin p = sa * sb; return p[31:0]; end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [TAG_W+31:0] e;
    #1;
    if (!rst && !flush && req_valid && req_ready) begin
      expq.push_back({req_tag, hand_on ? hand_val : gold(req_op, rs1, rs2)});
      n_acc++;
    end
    if (!rst && !flush && resp_ready) begin
      if (expq.size() == 0) begin
        chk("no_stale_resp", resp_valid, 1'b0);
      end else if (resp_valid) begin
        e = expq.pop_front();
        chk("resp_data", resp_data, e[31:0]);
        chk("resp_tag", resp_tag, e[TAG_W+31:32]);
        n_pop++;
        pop_cyc.push_back(cyc);
      end
    end
    chk("credit", expq.size() <= OUT_DEPTH, 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (flush) expq.delete();
  endtask

  task automatic single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b; req_tag = tag;
    hand_on = 1'b1; hand_val = exp;
    #1;
    chk("single_ready", req_ready, 1'b1);
    cycle();
    req_valid = 1'b0; hand_on = 1'b0; rs1 = 32'd0; rs2 = 32'd0;
    for (int i = 0; i < LAT; i++) begin
      chk("lat_no_resp_early", resp_valid, 1'b0);
      cycle();
    end
    chk("lat_resp_valid", resp_valid, 1'b1);
    chk("lat_busy", busy, 1'b1);
    chk("lat_data", resp_data, exp);
    chk("lat_tag", resp_tag, tag);
    resp_ready = 1'b1;
    cycle();
    chk("busy_after_pop", busy, 1'b0);
    chk("valid_after_pop", resp_valid, 1'b0);
  endtask

  initial begin
    int acc0;
    int pop0;
    #2;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", resp_tag, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("mul_en", mul_en, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1'b1);

    single(2'b00, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB);

    pop_cyc.delete();
    resp_ready = 1'b1;
    req_valid = 1'b1; hand_on = 1'b1;
    req_op = 2'b01; rs1 = 32'h80000000; rs2 = 32'h80000000; req_tag = 5'd1; hand_val = 32'h40000000;
    cycle();
    req_op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; req_tag = 5'd2; hand_val = 32'hFFFFFFFE;
    cycle();
    req_op = 2'b10; rs1 = 32'hFFFFFFFF; rs2 = 32'h00000002; req_tag = 5'd3; hand_val = 32'hFFFFFFFF;
    cycle();
    req_valid = 1'b0; hand_on = 1'b0;
    for (int i = 0; i < 30 && expq.size() > 0; i++) cycle();
    chk("b2b_drained", expq.size(), 0);
    chk("b2b_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_consec1", pop_cyc[1] - pop_cyc[0], 1);
      chk("b2b_consec2", pop_cyc[2] - pop_cyc[1], 1);
    end

    resp_ready = 1'b0;
    acc0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      req_op = 2'($urandom_range(0, 3)); rs1 = $urandom; rs2 = $urandom; req_tag = 5'($urandom_range(0, 31));
      cycle();
    end
    chk("full_accepts", n_acc - acc0, OUT_DEPTH);
    chk("full_ready_low", req_ready, 1'b0);
    chk("full_resp_valid", resp_valid, 1'b1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("no_same_cycle_credit", req_ready, 1'b0);
    pop0 = n_pop;
    cycle();
    chk("ready_after_pop", req_ready, 1'b1);
    for (int i = 0; i < 40 && expq.size() > 0; i++) cycle();
    chk("full_drained", expq.size(), 0);
    chk("full_pops", n_pop - pop0, OUT_DEPTH);

    acc0 = n_acc;
    pop0 = n_pop;
    req_valid = 1'b1;
    for (int i = 0; i < 300 && (n_acc - acc0) < 20; i++) begin
      req_op = 2'($urandom_range(0, 3)); rs1 = $urandom; rs2 = $urandom; req_tag = 5'($urandom_range(0, 31));
      if (i % 7 == 3) rs1 = 32'h80000000;
      resp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 60 && expq.size() > 0; i++) cycle();
    chk("rand_accepts", n_acc - acc0, 20);
    chk("rand_pops", n_pop - pop0, 20);

    resp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_op = 2'($urandom_range(0, 3)); rs1 = $urandom; rs2 = $urandom; req_tag = 5'(i);
      cycle();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    flush = 1'b1;
    #1;
    chk("flush_ready_low", req_ready, 1'b0);
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 1'b0);
    chk("flush_ready", req_ready, 1'b1);
    chk("flush_valid", resp_valid, 1'b0);
    for (int i = 0; i < 15; i++) cycle();
    chk("flush_no_resp", resp_valid, 1'b0);
    single(2'b00, 32'd6, 32'd7, 5'd9, 32'd42);

    resp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      req_op = 2'($urandom_range(0, 3)); rs1 = $urandom; rs2 = $urandom; req_tag = 5'(i + 1);
      cycle();
    end
    req_valid = 1'b0;
    cycle();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_valid", resp_valid, 1'b1);
    req_valid = 1'b1; rs1 = 32'd5; rs2 = 32'd5;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", resp_valid, 1'b0);
    chk("mid_rst_data", resp_data, 32'd0);
    chk("mid_rst_tag", resp_tag, 5'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_mul_a", mul_a, 32'd0);
    chk("mid_rst_mul_b", mul_b, 32'd0);
    expq.delete();
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    resp_ready = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    chk("post_rst_no_resp", resp_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
